fpga_bridge_vc_sched: RTL and testbench
=======================================

Name: fpga_bridge_vc_sched

Overview:
- Credit-based virtual-channel scheduler for the bridge transmit path.
- Three per-NoC 32-bit flit sources (NoC1..NoC3) compete for a single 32-bit chip link.
- Tracks per-channel downstream credits, selects one eligible channel per cycle (round-robin), pops its source and drives a registered data/channel pair onto the link.
- Sits between the per-NoC serializing FIFOs and the link pads; credit returns arrive already synchronized to clk.

Parameters:
- CREDIT_WIDTH, 9: width of each credit counter.
- INIT_CREDITS, 9'd255: counter reset value; equals downstream buffer depth per channel.

Ports:
- clk, input, 1: scheduler/link clock.
- rst, input, 1: synchronous, active-high reset.
- sched_en, input, 1: when low, no grants are issued; credit accounting continues.
- src_data_1 / src_data_2 / src_data_3, input, 32 each: head flit of each NoC source.
- src_val_1 / src_val_2 / src_val_3, input, 1 each: source head valid.
- src_rdy_1 / src_rdy_2 / src_rdy_3, output, 1 each: combinational pop/grant, one-hot or zero.
- credit_in, input, 3: one-cycle credit-return pulses; bit0 = NoC1, bit1 = NoC2, bit2 = NoC3.
- data_to_chip, output, 32: registered link data.
- data_channel, output, 2: registered link channel; 0 = idle, 1/2/3 = NoC1/2/3.
- credit_cnt_1 / credit_cnt_2 / credit_cnt_3, output, CREDIT_WIDTH each: current credit counts.
- credit_err, output, 1: sticky; set on credit return while the counter is already at INIT_CREDITS.

Behaviour:
- Reset values:
  - credit_cnt_* = INIT_CREDITS
  - data_to_chip = 0, data_channel = 0, credit_err = 0
  - rr pointer last_grant = 3, so NoC1 has first priority.
  - src_rdy_* = 0 while rst is high.
- Eligibility: channel c is eligible iff sched_en && src_val_c && credit_cnt_c != 0.
- Round-robin order starts after last_grant:
  - last=1 → 2,3,1
  - last=2 → 3,1,2
  - last=3 → 1,2,3
- The first eligible channel in that order gets src_rdy_c = 1 in the same cycle (combinational). At most one src_rdy is high.
- Handshake: transfer occurs when src_val_c && src_rdy_c. The source must not depend on src_rdy to assert val.
- Latency: a flit granted in cycle N appears on data_to_chip/data_channel at cycle N+1, for exactly one cycle.
- No grant in a cycle → next cycle data_channel = 0 and data_to_chip = 0.
- last_grant updates only on a grant; otherwise it holds.
- Credit arithmetic, per channel, each cycle:
  - grant only → cnt-1
  - credit_in only → cnt+1
  - both → unchanged
- Saturation: credit_in while cnt == INIT_CREDITS and no simultaneous grant → cnt holds and credit_err sets. credit_err clears only on rst.
- Zero credit: a channel at 0 is ineligible and is skipped. Other channels proceed, with no head-of-line blocking across channels.
- A credit arriving while cnt == 0 allows a grant next cycle, never in the same cycle (eligibility uses the registered count).
- sched_en deasserted mid-stream: an already-registered output flit still drives its cycle; no new grants.
- rst mid-operation: all counters reload to INIT_CREDITS, the pointer resets, and the output goes idle the next cycle. Unsent source flits remain in the sources.
- Flits are never duplicated or dropped. Per-channel flit order is preserved.

Optional Feature:
- Macro: FPGA_BRIDGE_SCHED_STRICT_PRIO_EN.
- Defined: fixed priority NoC3 > NoC2 > NoC1 among eligible channels (responses drain first for deadlock avoidance); last_grant is not implemented.
- Undefined: round-robin as specified above.
- Credit logic, latency and outputs are identical in both modes.

Test Plan:
- Reset, all three vals held high, credit_in = 0:
  - Grants cycle 1,2,3,1,... each cycle.
  - data_channel sequence 1,2,3 starting the cycle after the first grant.
  - Each credit_cnt decrements by 1 per own grant.
- Only NoC2 valid for 300 cycles, no credits returned:
  - Exactly 255 flits with data_channel = 2, then idle.
  - credit_cnt_2 = 0; src_rdy_2 = 0 thereafter.
  - One credit_in[1] pulse → exactly one more flit, two cycles later.
- NoC1 at 0 credits, NoC1 and NoC3 valid:
  - Only NoC3 is granted; NoC1 is never granted and NoC3 flows at full rate.
- Simultaneous grant and credit_in on NoC3 with cnt = 10 → cnt stays 10. A credit pulse at cnt = 255 → cnt stays 255 and credit_err = 1 (sticky).
- rst pulsed mid-burst with counters at 100/50/0:
  - Next cycle all counters = 255 and data_channel = 0.
  - First grant after reset goes to NoC1 when all are valid.
- With FPGA_BRIDGE_SCHED_STRICT_PRIO_EN defined, all valid with ample credits:
  - NoC3 is granted continuously; NoC2 only when NoC3 is invalid; NoC1 only when both are invalid.

Source files
------------

// File: rtl/fpga_bridge_vc_sched_if.sv
// Scheduler-side bundle: NoC source handshakes, credit returns, link outputs and credit status.
// The slave modport is the scheduler's view; master is the view of the sources/link/testbench.
interface fpga_bridge_vc_sched_if #(
    parameter int CREDIT_WIDTH = 9
);
    logic                    sched_en;
    logic [31:0]             src_data_1, src_data_2, src_data_3;
    logic                    src_val_1, src_val_2, src_val_3;
    logic                    src_rdy_1, src_rdy_2, src_rdy_3;
    logic [2:0]              credit_in;
    logic [31:0]             data_to_chip;
    logic [1:0]              data_channel;
    logic [CREDIT_WIDTH-1:0] credit_cnt_1, credit_cnt_2, credit_cnt_3;
    logic                    credit_err;

    modport slave (
        input  sched_en, src_data_1, src_data_2, src_data_3,
               src_val_1, src_val_2, src_val_3, credit_in,
        output src_rdy_1, src_rdy_2, src_rdy_3, data_to_chip, data_channel,
               credit_cnt_1, credit_cnt_2, credit_cnt_3, credit_err
    );

    modport master (
        output sched_en, src_data_1, src_data_2, src_data_3,
               src_val_1, src_val_2, src_val_3, credit_in,
        input  src_rdy_1, src_rdy_2, src_rdy_3, data_to_chip, data_channel,
               credit_cnt_1, credit_cnt_2, credit_cnt_3, credit_err
    );
endinterface

// File: rtl/fpga_bridge_vc_sched.sv
// Credit-based 3-channel VC scheduler feeding one registered 32-bit chip link.
// Define FPGA_BRIDGE_SCHED_STRICT_PRIO_EN for fixed priority NoC3 > NoC2 > NoC1 instead of round-robin.
module fpga_bridge_vc_sched #(
    parameter int                    CREDIT_WIDTH = 9,
    parameter logic [CREDIT_WIDTH-1:0] INIT_CREDITS = CREDIT_WIDTH'(255)
) (
    input logic                    clk,
    input logic                    rst,
    fpga_bridge_vc_sched_if.slave  bus
);
    logic [31:0]             src_data [3];
    logic [2:0]              src_val;
    logic [2:0]              credit_in;
    logic [2:0]              eligible;
    logic [2:0]              grant;
    logic [CREDIT_WIDTH-1:0] cnt_q [3];
    logic [CREDIT_WIDTH-1:0] cnt_d [3];
    logic [31:0]             data_q, data_d;
    logic [1:0]              chan_q, chan_d;
    logic                    err_q, err_d;
`ifndef FPGA_BRIDGE_SCHED_STRICT_PRIO_EN
    logic [1:0]              last_grant_q, last_grant_d;
`endif

    assign src_data[0] = bus.src_data_1;
    assign src_data[1] = bus.src_data_2;
    assign src_data[2] = bus.src_data_3;
    assign src_val     = {bus.src_val_3, bus.src_val_2, bus.src_val_1};
    assign credit_in   = bus.credit_in;

    // Eligibility looks only at the registered count, so a returned credit helps next cycle at the earliest.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            eligible[c] = bus.sched_en && src_val[c] && (cnt_q[c] != '0);
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = '0;
        if (!rst) begin
`ifdef FPGA_BRIDGE_SCHED_STRICT_PRIO_EN
            if      (eligible[2]) grant = 3'b100;
            else if (eligible[1]) grant = 3'b010;
            else if (eligible[0]) grant = 3'b001;
`else
            case (last_grant_q)
                2'd1: begin
                    if      (eligible[1]) grant = 3'b010;
                    else if (eligible[2]) grant = 3'b100;
                    else if (eligible[0]) grant = 3'b001;
                end
                2'd2: begin
                    if      (eligible[2]) grant = 3'b100;
                    else if (eligible[0]) grant = 3'b001;
                    else if (eligible[1]) grant = 3'b010;
                end
                default: begin
                    if      (eligible[0]) grant = 3'b001;
                    else if (eligible[1]) grant = 3'b010;
                    else if (eligible[2]) grant = 3'b100;
                end
            endcase
`endif
        end
    end

    always_comb begin
        chan_d = 2'd0;
        data_d = '0;
        case (grant)
            3'b001:  begin chan_d = 2'd1; data_d = src_data[0]; end
            3'b010:  begin chan_d = 2'd2; data_d = src_data[1]; end
            3'b100:  begin chan_d = 2'd3; data_d = src_data[2]; end
            default: begin chan_d = 2'd0; data_d = '0;          end
        endcase
`ifndef FPGA_BRIDGE_SCHED_STRICT_PRIO_EN
        last_grant_d = (grant != '0) ? chan_d : last_grant_q;
`endif
    end

    // A grant and a return on the same channel cancel; a return at full count is an overflow.
    always_comb begin
        err_d = err_q;
        for (int c = 0; c < 3; c++) begin
            cnt_d[c] = cnt_q[c];
            case ({grant[c], credit_in[c]})
                2'b10: cnt_d[c] = cnt_q[c] - CREDIT_WIDTH'(1);
                2'b01: begin
                    if (cnt_q[c] == INIT_CREDITS) err_d = 1'b1;
                    else                          cnt_d[c] = cnt_q[c] + CREDIT_WIDTH'(1);
                end
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) cnt_q[c] <= INIT_CREDITS;
            data_q       <= '0;
            chan_q       <= 2'd0;
            err_q        <= 1'b0;
`ifndef FPGA_BRIDGE_SCHED_STRICT_PRIO_EN
            last_grant_q <= 2'd3;
`endif
        end else begin
            for (int c = 0; c < 3; c++) cnt_q[c] <= cnt_d[c];
            data_q       <= data_d;
            chan_q       <= chan_d;
            err_q        <= err_d;
`ifndef FPGA_BRIDGE_SCHED_STRICT_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.src_rdy_1    = grant[0];
    assign bus.src_rdy_2    = grant[1];
    assign bus.src_rdy_3    = grant[2];
    assign bus.data_to_chip = data_q;
    assign bus.data_channel = chan_q;
    assign bus.credit_cnt_1 = cnt_q[0];
    assign bus.credit_cnt_2 = cnt_q[1];
    assign bus.credit_cnt_3 = cnt_q[2];
    assign bus.credit_err   = err_q;
endmodule

// File: tb/tb_fpga_bridge_vc_sched.sv
// Randomized bench for fpga_bridge_vc_sched against a queue-based transaction model.
// Honours FPGA_BRIDGE_SCHED_STRICT_PRIO_EN the same way as the design.
module tb_fpga_bridge_vc_sched;
    localparam int CW   = 9;
    localparam int INIT = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpga_bridge_vc_sched_if #(.CREDIT_WIDTH(CW)) bus ();

    fpga_bridge_vc_sched #(.CREDIT_WIDTH(CW), .INIT_CREDITS(9'd255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] src_q [3][$];
    int          m_cred [3];
    int          m_last;
    bit          m_err;
    logic [31:0] m_data;
    int          m_chan;
    int          seen [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channel (1..3) the scheduler should grant, or 0.
    function automatic int model_pick(input bit en, input logic [2:0] v);
        int c;
        for (int k = 1; k <= 3; k++) begin
`ifdef FPGA_BRIDGE_SCHED_STRICT_PRIO_EN
            c = 4 - k;
`else
            c = (m_last + k - 1) % 3 + 1;
`endif
            if (en && v[c-1] && m_cred[c-1] != 0) return c;
        end
        return 0;
    endfunction

    // One clock: drive at negedge, check grant, model the edge, check registered state.
    task automatic cycle(input bit en, input logic [2:0] vmask, input logic [2:0] cr, input bit r);
        int g;
        for (int c = 0; c < 3; c++)
            if (vmask[c] && src_q[c].size() == 0) src_q[c].push_back($urandom);
        rst            = r;
        bus.sched_en   = en;
        bus.src_val_1  = vmask[0];
        bus.src_val_2  = vmask[1];
        bus.src_val_3  = vmask[2];
        bus.src_data_1 = (src_q[0].size() != 0) ? src_q[0][0] : 32'h0;
        bus.src_data_2 = (src_q[1].size() != 0) ? src_q[1][0] : 32'h0;
        bus.src_data_3 = (src_q[2].size() != 0) ? src_q[2][0] : 32'h0;
        bus.credit_in  = cr;
        #1;
        g = r ? 0 : model_pick(en, vmask);
        check("src_rdy", {bus.src_rdy_3, bus.src_rdy_2, bus.src_rdy_1},
              (g == 0) ? 64'd0 : (64'd1 << (g - 1)));
        @(posedge clk);
        if (r) begin
            for (int c = 0; c < 3; c++) m_cred[c] = INIT;
            m_last = 3; m_err = 1'b0; m_data = '0; m_chan = 0;
        end else begin
            for (int c = 1; c <= 3; c++) begin
                if (g == c && !cr[c-1]) m_cred[c-1]--;
                else if (g != c && cr[c-1]) begin
                    if (m_cred[c-1] == INIT) m_err = 1'b1;
                    else m_cred[c-1]++;
                end
            end
            if (g != 0) begin
                m_data = src_q[g-1].pop_front();
                m_chan = g;
                m_last = g;
            end else begin
                m_data = '0;
                m_chan = 0;
            end
        end
        #1;
        check("data_channel", bus.data_channel, m_chan);
        check("data_to_chip", bus.data_to_chip, m_data);
        check("credit_cnt_1", bus.credit_cnt_1, m_cred[0]);
        check("credit_cnt_2", bus.credit_cnt_2, m_cred[1]);
        check("credit_cnt_3", bus.credit_cnt_3, m_cred[2]);
        check("credit_err", bus.credit_err, m_err);
        seen[int'(bus.data_channel)]++;
        @(negedge clk);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) seen[i] = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.sched_en = 1'b0;
        bus.src_val_1 = 1'b0; bus.src_val_2 = 1'b0; bus.src_val_3 = 1'b0;
        bus.src_data_1 = '0; bus.src_data_2 = '0; bus.src_data_3 = '0;
        bus.credit_in = '0;
        for (int c = 0; c < 3; c++) m_cred[c] = INIT;
        m_last = 3; m_err = 1'b0; m_data = '0; m_chan = 0;
        clear_seen();
        @(negedge clk);

        // Reset state
        cycle(1'b0, 3'b000, 3'b000, 1'b1);
        cycle(1'b1, 3'b111, 3'b000, 1'b1);
        check("reset_cnts", {bus.credit_cnt_1, bus.credit_cnt_2, bus.credit_cnt_3}, {3{9'd255}});
        check("reset_link", {bus.data_channel, bus.data_to_chip}, 34'd0);
        check("reset_rdy", {bus.src_rdy_3, bus.src_rdy_2, bus.src_rdy_1}, 3'b000);

        // All valid, no credit returns
        for (int i = 0; i < 9; i++) cycle(1'b1, 3'b111, 3'b000, 1'b0);
`ifdef FPGA_BRIDGE_SCHED_STRICT_PRIO_EN
        check("all_valid_cnts", {bus.credit_cnt_1, bus.credit_cnt_2, bus.credit_cnt_3},
              {9'd255, 9'd255, 9'd246});
`else
        check("all_valid_cnts", {bus.credit_cnt_1, bus.credit_cnt_2, bus.credit_cnt_3},
              {3{9'd252}});
`endif

        // NoC2 alone until its credits run out, then a single credit return
        cycle(1'b0, 3'b000, 3'b000, 1'b1);
        clear_seen();
        for (int i = 0; i < 300; i++) cycle(1'b1, 3'b010, 3'b000, 1'b0);
        check("noc2_flits", seen[2], 255);
        check("noc2_cnt_zero", bus.credit_cnt_2, 9'd0);
        check("noc2_rdy_low", bus.src_rdy_2, 1'b0);
        clear_seen();
        cycle(1'b1, 3'b010, 3'b010, 1'b0);
        check("credit_no_same_cycle", seen[2], 0);
        cycle(1'b1, 3'b010, 3'b000, 1'b0);
        check("credit_one_flit", seen[2], 1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'b010, 3'b000, 1'b0);
        check("credit_only_one", seen[2], 1);

        // NoC1 starved, NoC3 must flow without head-of-line blocking
        cycle(1'b0, 3'b000, 3'b000, 1'b1);
        for (int i = 0; i < 255; i++) cycle(1'b1, 3'b001, 3'b000, 1'b0);
        check("noc1_cnt_zero", bus.credit_cnt_1, 9'd0);
        clear_seen();
        for (int i = 0; i < 20; i++) cycle(1'b1, 3'b101, 3'b000, 1'b0);
        check("noc1_skipped", seen[1], 0);
        check("noc3_full_rate", seen[3], 20);

        // Grant and credit in the same cycle; overflow on a full counter
        for (int i = 0; i < 300 && m_cred[2] != 10; i++) cycle(1'b1, 3'b100, 3'b000, 1'b0);
        cycle(1'b1, 3'b100, 3'b100, 1'b0);
        check("grant_plus_credit", bus.credit_cnt_3, 9'd10);
        cycle(1'b0, 3'b000, 3'b000, 1'b1);
        cycle(1'b1, 3'b000, 3'b001, 1'b0);
        check("overflow_cnt", bus.credit_cnt_1, 9'd255);
        check("overflow_err", bus.credit_err, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'b111, 3'b000, 1'b0);
        check("err_sticky", bus.credit_err, 1'b1);

        // Counters at 100/50/0, then reset mid-burst
        cycle(1'b0, 3'b000, 3'b000, 1'b1);
        for (int i = 0; i < 155; i++) cycle(1'b1, 3'b001, 3'b000, 1'b0);
        for (int i = 0; i < 205; i++) cycle(1'b1, 3'b010, 3'b000, 1'b0);
        for (int i = 0; i < 255; i++) cycle(1'b1, 3'b100, 3'b000, 1'b0);
        check("pre_reset_cnts", {bus.credit_cnt_1, bus.credit_cnt_2, bus.credit_cnt_3},
              {9'd100, 9'd50, 9'd0});
        cycle(1'b1, 3'b111, 3'b000, 1'b1);
        check("mid_reset_cnts", {bus.credit_cnt_1, bus.credit_cnt_2, bus.credit_cnt_3},
              {3{9'd255}});
        check("mid_reset_idle", bus.data_channel, 2'd0);
        cycle(1'b1, 3'b111, 3'b000, 1'b0);
`ifdef FPGA_BRIDGE_SCHED_STRICT_PRIO_EN
        check("first_after_reset", bus.data_channel, 2'd3);
`else
        check("first_after_reset", bus.data_channel, 2'd1);
`endif

        // Random traffic, credit returns, enables and resets
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 8) != 0, 3'($urandom),
                  {($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0},
                  ($urandom % 250) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
